// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction-fetch unit and the load/store unit.
// LSU wins by default; a starve counter forces an IFU grant and a watchdog aborts stuck transactions.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          ifu_resp_valid_q, ifu_resp_valid_d;
  logic [31:0]   ifu_rdata_q, ifu_rdata_d;
  logic          ifu_err_q, ifu_err_d;
  logic          lsu_resp_valid_q, lsu_resp_valid_d;
  logic [31:0]   lsu_rdata_q, lsu_rdata_d;
  logic          lsu_err_q, lsu_err_d;

  logic pick_lsu, pick_ifu, starved, timed_out, finish, fin_err;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    starve_d         = starve_q;
    tmo_d            = tmo_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wen_d            = wen_q;
    wmask_d          = wmask_q;
    ifu_resp_valid_d = 1'b0;
    ifu_rdata_d      = '0;
    ifu_err_d        = 1'b0;
    lsu_resp_valid_d = 1'b0;
    lsu_rdata_d      = '0;
    lsu_err_d        = 1'b0;
    ifu_req_ready    = 1'b0;
    lsu_req_ready    = 1'b0;
    mem_req_valid    = 1'b0;
    finish           = 1'b0;
    fin_err          = 1'b0;

    starved   = (starve_q == SW'(STARVE_LIMIT));
    pick_lsu  = lsu_req_valid && !(ifu_req_valid && starved);
    pick_ifu  = ifu_req_valid && !pick_lsu;
    timed_out = (tmo_q == TW'(TIMEOUT));

    case (state_q)
      S_IDLE: begin
        lsu_req_ready = pick_lsu && !reset;
        ifu_req_ready = pick_ifu && !reset;
        if (pick_lsu) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          tmo_d   = '0;
          state_d = S_REQ;
          if (ifu_req_valid && !starved) starve_d = starve_q + 1'b1;
        end else if (pick_ifu) begin
          owner_d  = OWN_IFU;
          addr_d   = ifu_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = 4'hF;
          tmo_d    = '0;
          starve_d = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        tmo_d = tmo_q + 1'b1;
        if (timed_out) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          mem_req_valid = !reset;
          if (mem_req_ready) begin
            // zero-latency memory answers in the same cycle it accepts
            if (mem_resp_valid) finish = 1'b1;
            else                state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (timed_out) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else if (mem_resp_valid) begin
          finish = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d = S_RESP;
      if (owner_q == OWN_IFU) begin
        ifu_resp_valid_d = 1'b1;
        ifu_err_d        = fin_err;
        ifu_rdata_d      = fin_err ? 32'h0 : mem_rdata;
      end else begin
        lsu_resp_valid_d = 1'b1;
        lsu_err_d        = fin_err;
        lsu_rdata_d      = (fin_err || wen_q) ? 32'h0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      owner_q          <= OWN_IFU;
      starve_q         <= '0;
      tmo_q            <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wen_q            <= 1'b0;
      wmask_q          <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      ifu_err_q        <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_rdata_q      <= '0;
      lsu_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      starve_q         <= starve_d;
      tmo_q            <= tmo_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      wen_q            <= wen_d;
      wmask_q          <= wmask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_rdata_q      <= ifu_rdata_d;
      ifu_err_q        <= ifu_err_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_rdata_q      <= lsu_rdata_d;
      lsu_err_q        <= lsu_err_d;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign ifu_err        = ifu_err_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign lsu_err        = lsu_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model plans every grant and memory reply;
// a separate monitor pops expected memory requests and responses whenever the DUT presents them.
module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_lsu; logic [31:0] rdata; bit err; int at; } resp_t;
  typedef struct { logic [31:0] addr; bit wen; logic [31:0] wdata; logic [3:0] wmask; int at; } mreq_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];
  bit          sched_rdy[int];
  bit          sched_rv[int];
  logic [31:0] sched_rd[int];
  bit          exp_mrv[int];

  int    errors = 0, checks = 0, cyc = 0;
  int    idle_at = 0, starve = 0;
  bit    mon_en = 0, rst_drv = 1;
  bit    ifu_pend = 0, lsu_pend = 0;
  logic [31:0] ifu_a = 0, lsu_a = 0, lsu_d = 0;
  bit          lsu_w = 0;
  logic [3:0]  lsu_m = 0;
  int    ifu_rate = 0, lsu_rate = 0, fix_d = -1, fix_l = -1;
  bit    use_rd = 0;
  logic [31:0] fix_rd = 0;
  string glog = "";
  resp_t mon_r;
  mreq_t mon_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string name);
    logic [200:0] o;
    o = {ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err, lsu_req_ready, lsu_resp_valid, lsu_rdata,
         lsu_err, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask};
    chk(name, {63'b0, |o}, 64'd0);
  endtask

  // Reference: decide grants from the arbitration rules and plan the memory's behaviour per transaction.
  task automatic model_eval();
    bit gi, gl, tmo;
    int d, l, g;
    logic [31:0] rd;
    gi = 0; gl = 0;
    if (reset) begin
      resp_q.delete();
      mreq_q.delete();
      idle_at = cyc + 1;
      starve  = 0;
    end else if (cyc >= idle_at) begin
      if (lsu_pend && !(ifu_pend && starve == STARVE_LIMIT)) gl = 1;
      else if (ifu_pend) gi = 1;
    end
    chk("ifu_req_ready", ifu_req_ready, gi);
    chk("lsu_req_ready", lsu_req_ready, gl);
    chk("mem_req_valid", mem_req_valid, exp_mrv.exists(cyc));
    if (lsu_req_ready) glog = {glog, "L"};
    else if (ifu_req_ready) glog = {glog, "I"};
    if (gi || gl) begin
      g   = cyc;
      d   = (fix_d >= 0) ? fix_d : $urandom_range(0, 3);
      l   = (fix_l >= 0) ? fix_l : $urandom_range(0, 3);
      rd  = use_rd ? fix_rd : $urandom;
      tmo = (d >= TIMEOUT);
      if (tmo) begin
        for (int k = 1; k <= TIMEOUT; k++) exp_mrv[g+k] = 1;
        for (int k = 1; k <= TIMEOUT + 1; k++) sched_rdy[g+k] = 0;
        resp_q.push_back('{gl, 32'h0, 1'b1, g + TIMEOUT + 2});
        idle_at = g + TIMEOUT + 3;
      end else begin
        for (int k = 1; k <= d + 1; k++) exp_mrv[g+k] = 1;
        for (int k = 1; k <= d; k++) sched_rdy[g+k] = 0;
        sched_rdy[g+1+d] = 1;
        for (int k = 0; k < l; k++) sched_rv[g+1+d+k] = 0;
        sched_rv[g+1+d+l] = 1;
        sched_rd[g+1+d+l] = rd;
        if (gl) mreq_q.push_back('{lsu_a, lsu_w, lsu_d, lsu_m, g + 1 + d});
        else    mreq_q.push_back('{ifu_a, 1'b0, 32'h0, 4'hF, g + 1 + d});
        resp_q.push_back('{gl, (gl && lsu_w) ? 32'h0 : rd, 1'b0, g + 2 + d + l});
        idle_at = g + 3 + d + l;
      end
      if (gl && ifu_pend && starve < STARVE_LIMIT) starve++;
      if (gi) starve = 0;
      if (gl) lsu_pend = 0;
      else    ifu_pend = 0;
    end
    if (!ifu_pend && $urandom_range(0, 99) < ifu_rate) begin
      ifu_pend = 1;
      ifu_a    = $urandom;
    end
    if (!lsu_pend && $urandom_range(0, 99) < lsu_rate) begin
      lsu_pend = 1;
      lsu_a    = $urandom;
      lsu_d    = $urandom;
      lsu_w    = 1'($urandom_range(0, 1));
      lsu_m    = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    reset          = rst_drv;
    ifu_req_valid  = ifu_pend;
    ifu_addr       = ifu_a;
    lsu_req_valid  = lsu_pend;
    lsu_addr       = lsu_a;
    lsu_wen        = lsu_w;
    lsu_wdata      = lsu_d;
    lsu_wmask      = lsu_m;
    mem_req_ready  = sched_rdy.exists(cyc) ? sched_rdy[cyc] : 1'($urandom_range(0, 1));
    mem_resp_valid = sched_rv.exists(cyc) ? sched_rv[cyc] : 1'($urandom_range(0, 1));
    mem_rdata      = sched_rd.exists(cyc) ? sched_rd[cyc] : $urandom;
    @(negedge clk);
    model_eval();
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while (!(cyc >= idle_at && !ifu_pend && !lsu_pend) && n < 2000) begin
      step();
      n++;
    end
    chk("idle_reached", {63'b0, n < 2000}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifu_resp_valid || lsu_resp_valid) begin
        chk("resp_expected", {63'b0, resp_q.size() != 0}, 64'd1);
        if (resp_q.size() != 0) begin
          mon_r = resp_q.pop_front();
          chk("resp_cycle", cyc, mon_r.at);
          chk("ifu_resp_valid", ifu_resp_valid, !mon_r.is_lsu);
          chk("lsu_resp_valid", lsu_resp_valid, mon_r.is_lsu);
          chk("resp_rdata", mon_r.is_lsu ? lsu_rdata : ifu_rdata, mon_r.rdata);
          chk("resp_err", mon_r.is_lsu ? lsu_err : ifu_err, mon_r.err);
          chk("other_resp_zero", mon_r.is_lsu ? {ifu_rdata, ifu_err} : {lsu_rdata, lsu_err}, 64'd0);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        chk("mreq_expected", {63'b0, mreq_q.size() != 0}, 64'd1);
        if (mreq_q.size() != 0) begin
          mon_m = mreq_q.pop_front();
          chk("mreq_cycle", cyc, mon_m.at);
          chk("mem_addr", mem_addr, mon_m.addr);
          chk("mem_wen", mem_wen, mon_m.wen);
          chk("mem_wdata", mem_wdata, mon_m.wdata);
          chk("mem_wmask", mem_wmask, mon_m.wmask);
        end
      end
    end
  end

  initial begin
    reset = 1; ifu_req_valid = 0; ifu_addr = 0; lsu_req_valid = 0; lsu_addr = 0;
    lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    rst_drv = 1;
    repeat (3) step();
    mon_en = 1;
    chk_all_zero("reset_outputs_zero");
    rst_drv = 0;
    step();

    // IFU-only read, memory ready at once and answers one cycle later
    fix_d = 0; fix_l = 1; use_rd = 1; fix_rd = 32'h0000_0413;
    ifu_pend = 1; ifu_a = 32'h8000_0000;
    run_idle();

    // simultaneous IFU read and LSU write: LSU first, then IFU
    glog = "";
    ifu_pend = 1; ifu_a = 32'h8000_0004;
    lsu_pend = 1; lsu_a = 32'h8000_1000; lsu_w = 1; lsu_d = 32'hDEAD_BEEF; lsu_m = 4'b0011;
    run_idle();
    checks++;
    if (glog != "LI") begin
      errors++;
      $display("FAIL grant_order_simul: got %s expected LI", glog);
    end

    // both masters hold valid: four LSU grants, then IFU, and the pattern repeats
    glog = ""; use_rd = 0;
    ifu_rate = 100; lsu_rate = 100;
    for (int i = 0; i < 400 && glog.len() < 10; i++) step();
    ifu_rate = 0; lsu_rate = 0;
    checks++;
    if (glog.substr(0, 9) != "LLLLILLLLI") begin
      errors++;
      $display("FAIL starve_pattern: got %s expected LLLLILLLLI", glog);
    end
    run_idle();

    // watchdog: memory never accepts
    fix_d = TIMEOUT; fix_l = 0;
    ifu_pend = 1; ifu_a = 32'h8000_0100;
    run_idle();
    fix_d = 0; fix_l = 1;
    lsu_pend = 1; lsu_a = 32'h8000_2000; lsu_w = 0; lsu_d = 0; lsu_m = 4'hF;
    run_idle();

    // zero-latency memory
    fix_d = 0; fix_l = 0;
    lsu_pend = 1; lsu_a = 32'h8000_3000; lsu_w = 0; lsu_m = 4'hF;
    run_idle();

    // reset while waiting; the late memory reply must be dropped
    fix_d = 0; fix_l = 6;
    lsu_pend = 1; lsu_a = 32'h8000_4000; lsu_w = 0; lsu_m = 4'hF;
    step();
    step();
    step();
    rst_drv = 1;
    step();
    rst_drv = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_all_zero("post_reset_zero");
    end
    fix_d = 0; fix_l = 1;
    ifu_pend = 1; ifu_a = 32'h8000_0008;
    run_idle();

    // randomized traffic
    fix_d = -1; fix_l = -1; use_rd = 0;
    ifu_rate = 40; lsu_rate = 50;
    repeat (1500) step();
    ifu_rate = 0; lsu_rate = 0;
    run_idle();
    repeat (3) step();

    chk("resp_q_drained", resp_q.size(), 64'd0);
    chk("mreq_q_drained", mreq_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
